// File: rtl/regfile_csr_exu_if.sv
// regfile_csr_exu_if: data memory port between the execute unit and the memory
interface regfile_csr_exu_if;
   logic [31:0] mem_addr;
   logic        mem_ren;
   logic        mem_wen;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   modport master (output mem_addr, mem_ren, mem_wen, mem_wmask, mem_wdata, input mem_rdata);
   modport slave (input mem_addr, mem_ren, mem_wen, mem_wmask, mem_wdata, output mem_rdata);
endinterface

// File: rtl/regfile_csr_exu.sv
// regfile_csr_exu: RV32 GPR file, M-mode CSRs and execute unit (ALU, branch, load/store)
module regfile_csr_exu #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5,
   parameter int CADDR = 12,
   parameter int OPTW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RADDR-1:0] raddr1,
   input  logic [RADDR-1:0] raddr2,
   input  logic [RADDR-1:0] waddr,
   input  logic             wen,
   input  logic [XLEN-1:0]  wdata,
   output logic [XLEN-1:0]  rdata1,
   output logic [XLEN-1:0]  rdata2,
   output logic             a0_zero,
   input  logic [CADDR-1:0] csr_addr,
   input  logic             csr_wen,
   input  logic [XLEN-1:0]  csr_wdata,
   input  logic             ecall,
   input  logic             mret,
   input  logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  csr_rdata,
   output logic [XLEN-1:0]  mstatus,
   output logic [XLEN-1:0]  mtvec,
   output logic [XLEN-1:0]  mepc,
   output logic [XLEN-1:0]  mcause,
   input  logic [XLEN-1:0]  imm,
   input  logic [1:0]       src_sel,
   input  logic [OPTW-1:0]  exu_opt,
   input  logic [OPTW-1:0]  load_opt,
   input  logic [OPTW-1:0]  store_opt,
   input  logic [OPTW-1:0]  brch_opt,
   input  logic             if_unsigned,
   output logic [XLEN-1:0]  res,
   output logic             zero,
   regfile_csr_exu_if.master mem
);
   logic [XLEN-1:0] gpr [2**RADDR];
   logic [XLEN-1:0] a, b, alu, addr, ld_word, ld_val;
   logic [1:0]      off;
   logic            lt, eq, lts, ltu, st, ld;
   // x0 is never written, so it stays at its reset value of zero
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < 2**RADDR; i++) gpr[i] <= '0;
      else if (wen && waddr != '0) gpr[waddr] <= wdata;
   assign rdata1  = gpr[raddr1];
   assign rdata2  = gpr[raddr2];
   assign a0_zero = gpr[10] == '0;
   // mstatus fields: MIE bit 3, MPIE bit 7, MPP bits 12:11
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mstatus <= XLEN'(32'h1800);
         mtvec   <= '0;
         mepc    <= '0;
         mcause  <= '0;
      end else if (ecall) begin
         mepc    <= pc;
         mcause  <= XLEN'(11);
         mstatus <= {mstatus[XLEN-1:13], 2'b11, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
      end else if (mret)
         mstatus <= {mstatus[XLEN-1:13], 2'b11, mstatus[10:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};
      else if (csr_wen)
         case (csr_addr)
            12'h300: mstatus <= csr_wdata;
            12'h305: mtvec   <= csr_wdata;
            12'h341: mepc    <= csr_wdata;
            12'h342: mcause  <= csr_wdata;
            default: ;
         endcase
   assign csr_rdata = csr_addr == 12'h300 ? mstatus :
                      csr_addr == 12'h305 ? mtvec :
                      csr_addr == 12'h341 ? mepc :
                      csr_addr == 12'h342 ? mcause : '0;
   assign a  = src_sel == 2'd2 ? pc : rdata1;
   assign b  = src_sel == 2'd0 ? rdata2 : src_sel == 2'd3 ? csr_rdata : imm;
   assign lt = if_unsigned ? a < b : $signed(a) < $signed(b);
   always_comb begin
      alu = '0;
      case (exu_opt)
         4'd0: alu = a + b;
         4'd1: alu = a - b;
         4'd2: alu = a << b[4:0];
         4'd3: alu = {{(XLEN-1){1'b0}}, lt};
         4'd4: alu = a ^ b;
         4'd5: alu = a >> b[4:0];
         4'd6: alu = XLEN'($signed(a) >>> b[4:0]);
         4'd7: alu = a | b;
         4'd8: alu = a & b;
         4'd9: alu = b;
         default: alu = '0;
      endcase
   end
   assign eq   = rdata1 == rdata2;
   assign lts  = $signed(rdata1) < $signed(rdata2);
   assign ltu  = rdata1 < rdata2;
   assign zero = brch_opt == 4'd1 ? eq :
                 brch_opt == 4'd2 ? !eq :
                 brch_opt == 4'd3 ? lts :
                 brch_opt == 4'd4 ? !lts :
                 brch_opt == 4'd5 ? ltu :
                 brch_opt == 4'd6 ? !ltu : 1'b0;
   // a valid store code takes the memory port even when a load code is also present
   assign addr    = rdata1 + imm;
   assign off     = addr[1:0];
   assign st      = store_opt != '0 && store_opt <= 4'd3;
   assign ld      = !st && load_opt != '0 && load_opt <= 4'd5;
   assign ld_word = mem.mem_rdata >> {off, 3'b000};
   assign ld_val  = load_opt == 4'd1 ? {{(XLEN-8){ld_word[7]}}, ld_word[7:0]} :
                    load_opt == 4'd2 ? {{(XLEN-16){ld_word[15]}}, ld_word[15:0]} :
                    load_opt == 4'd4 ? {{(XLEN-8){1'b0}}, ld_word[7:0]} :
                    load_opt == 4'd5 ? {{(XLEN-16){1'b0}}, ld_word[15:0]} : ld_word;
   assign mem.mem_addr  = addr;
   assign mem.mem_ren   = ld;
   assign mem.mem_wen   = st;
   assign mem.mem_wmask = st ? 4'((store_opt == 4'd1 ? 4'b0001 : store_opt == 4'd2 ? 4'b0011 : 4'b1111) << off) : 4'b0000;
   assign mem.mem_wdata = rdata2 << {off, 3'b000};
   assign res = ld ? ld_val : alu;
endmodule

// File: tb/tb_regfile_csr_exu.sv
// tb_regfile_csr_exu: vector table, directed corner sequences and randomized model comparison
module tb_regfile_csr_exu;
   logic        clk = 0, rst;
   logic [4:0]  raddr1, raddr2, waddr;
   logic        wen, csr_wen, ecall, mret, if_unsigned, a0_zero, zero;
   logic [31:0] wdata, rdata1, rdata2, csr_wdata, pc, csr_rdata, mstatus, mtvec, mepc, mcause, imm, res;
   logic [11:0] csr_addr;
   logic [1:0]  src_sel;
   logic [3:0]  exu_opt, load_opt, store_opt, brch_opt;
   int checks = 0, errors = 0;
   logic [31:0] m_gpr [32];
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
   regfile_csr_exu_if mem_bus ();
   regfile_csr_exu dut (
      .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr), .wen(wen), .wdata(wdata),
      .rdata1(rdata1), .rdata2(rdata2), .a0_zero(a0_zero), .csr_addr(csr_addr), .csr_wen(csr_wen),
      .csr_wdata(csr_wdata), .ecall(ecall), .mret(mret), .pc(pc), .csr_rdata(csr_rdata), .mstatus(mstatus),
      .mtvec(mtvec), .mepc(mepc), .mcause(mcause), .imm(imm), .src_sel(src_sel), .exu_opt(exu_opt),
      .load_opt(load_opt), .store_opt(store_opt), .brch_opt(brch_opt), .if_unsigned(if_unsigned),
      .res(res), .zero(zero), .mem(mem_bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [1:0]  ss;
      logic [3:0]  op;
      logic        u;
      logic [31:0] r1, r2, im, p;
      logic [3:0]  br;
      logic [31:0] e_res;
      logic        e_zero;
   } vec_t;
   vec_t vt [14];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   function automatic logic [31:0] r_csr(input logic [11:0] a);
      return a == 12'h300 ? m_mstatus : a == 12'h305 ? m_mtvec : a == 12'h341 ? m_mepc : a == 12'h342 ? m_mcause : 32'h0;
   endfunction
   task automatic model_clock();
      if (rst) begin
         foreach (m_gpr[k]) m_gpr[k] = 0;
         m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
      end else begin
         if (wen && waddr != 0) m_gpr[waddr] = wdata;
         if (ecall) begin
            m_mepc = pc; m_mcause = 11;
            m_mstatus[7] = m_mstatus[3]; m_mstatus[3] = 0; m_mstatus[12:11] = 3;
         end else if (mret) begin
            m_mstatus[3] = m_mstatus[7]; m_mstatus[7] = 1; m_mstatus[12:11] = 3;
         end else if (csr_wen) begin
            if (csr_addr == 12'h300) m_mstatus = csr_wdata;
            if (csr_addr == 12'h305) m_mtvec = csr_wdata;
            if (csr_addr == 12'h341) m_mepc = csr_wdata;
            if (csr_addr == 12'h342) m_mcause = csr_wdata;
         end
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
   endtask
   task automatic idle();
      raddr1 = 0; raddr2 = 0; waddr = 0; wen = 0; wdata = 0; csr_addr = 0; csr_wen = 0; csr_wdata = 0;
      ecall = 0; mret = 0; pc = 0; imm = 0; src_sel = 0; exu_opt = 0; load_opt = 0; store_opt = 0;
      brch_opt = 0; if_unsigned = 0; mem_bus.mem_rdata = 0;
   endtask
   task automatic set_reg(input logic [4:0] a, input logic [31:0] v);
      wen = 1; waddr = a; wdata = v;
      step();
      wen = 0;
   endtask
   task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
      csr_wen = 1; csr_addr = a; csr_wdata = v;
      step();
      csr_wen = 0;
   endtask
   function automatic logic [31:0] r_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic u);
      int sx = x, sy = y;
      case (op)
         0: return x + y;
         1: return x - y;
         2: return x << (y % 32);
         3: return u ? 32'(x < y) : 32'(sx < sy);
         4: return x ^ y;
         5: return x >> (y % 32);
         6: return sx >>> (y % 32);
         7: return x | y;
         8: return x & y;
         9: return y;
         default: return 0;
      endcase
   endfunction
   function automatic logic r_br(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int sx = x, sy = y;
      case (op)
         1: return x == y;
         2: return x != y;
         3: return sx < sy;
         4: return sx >= sy;
         5: return x < y;
         6: return x >= y;
         default: return 0;
      endcase
   endfunction
   task automatic rand_iter();
      logic [11:0] cl [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
      logic [31:0] a, b, addr, w, e_res, e_wd;
      logic [7:0]  lb [4];
      logic [3:0]  e_mask;
      int off;
      logic st, ld, ok;
      raddr1 = 5'($urandom_range(0, 31)); raddr2 = 5'($urandom_range(0, 31));
      wen = 1'($urandom_range(0, 1)); waddr = 5'($urandom_range(0, 31));
      wdata = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
      csr_addr = cl[$urandom_range(0, 4)]; csr_wen = $urandom_range(0, 3) == 0; csr_wdata = $urandom;
      ecall = $urandom_range(0, 15) == 0; mret = $urandom_range(0, 15) == 0;
      pc = $urandom; imm = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63));
      src_sel = 2'($urandom_range(0, 3)); exu_opt = 4'($urandom_range(0, 15)); if_unsigned = 1'($urandom_range(0, 1));
      brch_opt = 4'($urandom_range(0, 6)); load_opt = 4'($urandom_range(0, 5)); store_opt = 4'($urandom_range(0, 3));
      mem_bus.mem_rdata = $urandom;
      #2;
      a = src_sel == 2 ? pc : m_gpr[raddr1];
      b = src_sel == 0 ? m_gpr[raddr2] : src_sel == 3 ? r_csr(csr_addr) : imm;
      addr = m_gpr[raddr1] + imm; off = addr % 4; w = mem_bus.mem_rdata;
      for (int k = 0; k < 4; k++) lb[k] = w[8*k +: 8];
      st = store_opt >= 1 && store_opt <= 3;
      ld = !st && load_opt != 0;
      ok = 1; e_res = r_alu(exu_opt, a, b, if_unsigned);
      if (ld) case (load_opt)
         1: e_res = {{24{lb[off][7]}}, lb[off]};
         4: e_res = {24'h0, lb[off]};
         2, 5: begin
            ok = off % 2 == 0;
            if (ok) e_res = load_opt == 2 ? {{16{lb[off+1][7]}}, lb[off+1], lb[off]} : {16'h0, lb[off+1], lb[off]};
         end
         default: begin ok = off == 0; e_res = w; end
      endcase
      chk("rnd_rdata1", rdata1, m_gpr[raddr1]);
      chk("rnd_rdata2", rdata2, m_gpr[raddr2]);
      chk("rnd_a0_zero", 32'(a0_zero), 32'(m_gpr[10] == 0));
      chk("rnd_csr_rdata", csr_rdata, r_csr(csr_addr));
      chk("rnd_mstatus", mstatus, m_mstatus);
      chk("rnd_mepc", mepc, m_mepc);
      if (ok) chk("rnd_res", res, e_res);
      chk("rnd_zero", 32'(zero), 32'(r_br(brch_opt, m_gpr[raddr1], m_gpr[raddr2])));
      chk("rnd_ren", 32'(mem_bus.mem_ren), 32'(ld));
      chk("rnd_wen", 32'(mem_bus.mem_wen), 32'(st));
      if (ld || st) chk("rnd_addr", mem_bus.mem_addr, addr);
      if (st && (store_opt == 1 || (store_opt == 2 && off % 2 == 0) || off == 0)) begin
         e_mask = store_opt == 1 ? 4'(1 << off) : store_opt == 2 ? 4'(3 << off) : 4'hF;
         e_wd = m_gpr[raddr2] << (8 * off);
         chk("rnd_wmask", 32'(mem_bus.mem_wmask), 32'(e_mask));
         chk("rnd_wdata", mem_bus.mem_wdata, e_wd);
      end
      step();
   endtask
   initial begin
      vt[0]  = '{2'd1, 4'd1, 1'b0, 32'd5, 32'd0, 32'd7, 32'd0, 4'd0, 32'hFFFFFFFE, 1'b0};
      vt[1]  = '{2'd1, 4'd3, 1'b1, 32'hFFFFFFFE, 32'd0, 32'd7, 32'd0, 4'd0, 32'd0, 1'b0};
      vt[2]  = '{2'd1, 4'd3, 1'b0, 32'hFFFFFFFE, 32'd0, 32'd7, 32'd0, 4'd0, 32'd1, 1'b0};
      vt[3]  = '{2'd0, 4'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd3, 32'd0, 1'b1};
      vt[4]  = '{2'd0, 4'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd5, 32'd0, 1'b0};
      vt[5]  = '{2'd2, 4'd0, 1'b0, 32'd3, 32'd3, 32'h10, 32'h80000000, 4'd1, 32'h80000010, 1'b1};
      vt[6]  = '{2'd0, 4'd2, 1'b0, 32'd1, 32'h24, 32'd0, 32'd0, 4'd2, 32'h10, 1'b1};
      vt[7]  = '{2'd0, 4'd6, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'd0, 4'd4, 32'hF8000000, 1'b0};
      vt[8]  = '{2'd0, 4'd5, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'd0, 4'd6, 32'h08000000, 1'b1};
      vt[9]  = '{2'd1, 4'd9, 1'b0, 32'd0, 32'd0, 32'h1234, 32'd0, 4'd0, 32'h1234, 1'b0};
      vt[10] = '{2'd0, 4'd12, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 4'd1, 32'd0, 1'b0};
      vt[11] = '{2'd0, 4'd4, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd2, 32'h0FF0, 1'b1};
      vt[12] = '{2'd0, 4'd7, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd4, 32'hFFF0, 1'b0};
      vt[13] = '{2'd0, 4'd8, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd6, 32'hF000, 1'b0};
      idle();
      rst = 1;
      step(); step();
      rst = 0;
      raddr1 = 5; #1;
      chk("rst_mstatus", mstatus, 32'h1800);
      chk("rst_mtvec", mtvec, 32'h0);
      chk("rst_mcause", mcause, 32'h0);
      chk("rst_x5", rdata1, 32'h0);
      chk("rst_a0_zero", 32'(a0_zero), 32'h1);
      set_reg(0, 32'hFFFF);
      set_reg(10, 7);
      raddr1 = 0; raddr2 = 10; #1;
      chk("x0_reads_0", rdata1, 32'h0);
      chk("x10_read", rdata2, 32'h7);
      chk("a0_nonzero", 32'(a0_zero), 32'h0);
      wen = 1; waddr = 3; wdata = 32'h55; raddr1 = 3; #1;
      chk("wr_not_yet_visible", rdata1, 32'h0);
      step(); wen = 0;
      chk("wr_visible_next", rdata1, 32'h55);
      for (int i = 0; i < 14; i++) begin
         set_reg(1, vt[i].r1);
         set_reg(2, vt[i].r2);
         raddr1 = 1; raddr2 = 2; src_sel = vt[i].ss; exu_opt = vt[i].op; if_unsigned = vt[i].u;
         imm = vt[i].im; pc = vt[i].p; brch_opt = vt[i].br; #1;
         chk($sformatf("vec%0d_res", i), res, vt[i].e_res);
         chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vt[i].e_zero));
      end
      idle();
      set_reg(1, 32'h100);
      set_reg(2, 32'hAB);
      raddr1 = 1; raddr2 = 2; mem_bus.mem_rdata = 32'h80FF1234;
      imm = 3; load_opt = 1; #1;
      chk("lb_res", res, 32'hFFFFFF80);
      chk("lb_ren", 32'(mem_bus.mem_ren), 32'h1);
      chk("lb_addr", mem_bus.mem_addr, 32'h103);
      imm = 2; load_opt = 5; #1;
      chk("lhu_res", res, 32'h000080FF);
      imm = 1; load_opt = 0; store_opt = 1; #1;
      chk("sb_mask", 32'(mem_bus.mem_wmask), 32'b0010);
      chk("sb_wdata", mem_bus.mem_wdata, 32'h0000AB00);
      chk("sb_ren", 32'(mem_bus.mem_ren), 32'h0);
      imm = 0; load_opt = 3; store_opt = 3; src_sel = 1; exu_opt = 0; #1;
      chk("both_wen", 32'(mem_bus.mem_wen), 32'h1);
      chk("both_ren", 32'(mem_bus.mem_ren), 32'h0);
      chk("both_res_alu", res, 32'h100);
      idle();
      csr_write(12'h300, 32'h1808);
      csr_write(12'h305, 32'h80000100);
      chk("mtvec_wr", mtvec, 32'h80000100);
      raddr1 = 1; src_sel = 3; csr_addr = 12'h305; #1;
      chk("src3_add", res, 32'h80000200);
      idle();
      csr_write(12'h7C0, 32'h123);
      csr_addr = 12'h7C0; #1;
      chk("unmapped_read", csr_rdata, 32'h0);
      chk("unmapped_mtvec", mtvec, 32'h80000100);
      ecall = 1; pc = 32'h80000010; step(); ecall = 0;
      chk("ecall_mepc", mepc, 32'h80000010);
      chk("ecall_mcause", mcause, 32'd11);
      chk("ecall_mstatus", mstatus, 32'h1880);
      mret = 1; step(); mret = 0;
      chk("mret_mstatus", mstatus, 32'h1888);
      chk("mret_mepc", mepc, 32'h80000010);
      ecall = 1; mret = 1; csr_wen = 1; csr_addr = 12'h341; csr_wdata = 32'hDEAD; pc = 32'h80000020;
      step(); ecall = 0;
      chk("prio_ecall_mepc", mepc, 32'h80000020);
      chk("prio_ecall_mstatus", mstatus, 32'h1880);
      csr_addr = 12'h300; csr_wdata = 0; step();
      chk("prio_mret_mstatus", mstatus, 32'h1888);
      idle();
      for (int i = 0; i < 400; i++) rand_iter();
      idle();
      set_reg(7, 32'h1234);
      raddr1 = 7; #2;
      rst = 1; #1;
      chk("async_rst_gpr", rdata1, 32'h0);
      chk("async_rst_mstatus", mstatus, 32'h1800);
      chk("async_rst_mepc", mepc, 32'h0);
      model_clock();
      rst = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
